// File: rtl/seq_pkg.sv
// Shared definitions for the serial link: default sizes and the serializer
// state encoding.
package seq_pkg;
   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
endpackage

// File: rtl/serializer_fifo.sv
// Small circular word buffer in front of the serializer shift register.
// The caller guarantees push only when not full and pop only when not empty.
module ser_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push) begin
            r_mem[r_wptr] <= din;
            r_wptr        <= ptr_inc(r_wptr);
         end
         if (pop) r_rptr <= ptr_inc(r_rptr);
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rptr];
   assign count = r_count;
endmodule

// File: rtl/serializer.sv
// Parallel-to-serial converter: buffered words are shifted out MSB first,
// back-to-back with no idle cycle between buffered words.
module serializer
   import seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             serialout,
   output logic             detect,
   output logic             busy
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int BW = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [BW-1:0]    r_bitcnt;
   logic [WIDTH-1:0] w_dout;
   logic [CW-1:0]    w_count;
   logic             w_push;
   logic             w_pop;
   logic             w_nempty;
   logic             w_last;

   assign w_nempty = (w_count != '0);
   assign w_last   = (r_bitcnt == BW'(WIDTH-1));

   ser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (data_in),
      .dout  (w_dout),
      .count (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_nempty) w_next = SHIFT;
         SHIFT:   if (w_last && !w_nempty) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ready comes from the registered count only, so a same-edge pop never frees a slot
   always_comb begin
      ready  = (w_count < CW'(DEPTH));
      w_push = load && ready;
      w_pop  = w_nempty && ((r_state == IDLE) || w_last);
   end

   // After the final shift the register is all zeros, so serialout idles low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift  <= '0;
         r_bitcnt <= '0;
      end else if (w_pop) begin
         r_shift  <= w_dout;
         r_bitcnt <= '0;
      end else if (r_state == SHIFT) begin
         r_shift  <= r_shift << 1;
         r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
      end
   end

   assign serialout = r_shift[WIDTH-1];
   assign detect    = (r_state == SHIFT);
   assign busy      = (r_state == SHIFT) || w_nempty;
endmodule

// File: tb/tb_serializer.sv
// Directed bench for the serializer: captures the serial stream and checks
// bytes, contiguity of detect, ready/busy behaviour and reset abort.
module tb_serializer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = '0;
   logic       load = 1'b0;
   logic       ready, serialout, detect, busy;

   int checks   = 0;
   int failures = 0;

   logic q[$];
   int   run      = 0;
   int   last_run = 0;

   serializer dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .load      (load),
      .ready     (ready),
      .serialout (serialout),
      .detect    (detect),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Stream monitor: records every valid bit and the length of each detect burst
   always @(negedge clk) begin
      if (detect) begin
         q.push_back(serialout);
         run <= run + 1;
      end else begin
         if (run > 0) last_run <= run;
         run <= 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input int b);
      logic [7:0] w = '0;
      for (int i = 0; i < 8; i++) w = {w[6:0], q[b+i]};
      return w;
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || detect) && n < 200) begin
         step();
         n++;
      end
      chk({tag, " idle_timeout"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
      step();
   endtask

   initial begin
      int base;
      int seen;

      // Reset state
      step(); step();
      chk("rst ready", ready, 1);
      chk("rst busy", busy, 0);
      chk("rst detect", detect, 0);
      chk("rst serialout", serialout, 0);
      rst = 1'b1;

      // Single word 7E: one-cycle latency, eight detect cycles
      base = q.size();
      load = 1'b1; data_in = 8'h7E;
      step();
      load = 1'b0;
      chk("t1 detect_after_accept", detect, 0);
      chk("t1 busy_after_accept", busy, 1);
      step();
      chk("t1 detect_first_bit", detect, 1);
      chk("t1 first_bit", serialout, 0);
      wait_idle("t1");
      chk("t1 byte", byte_at(base), 8'h7E);
      chk("t1 run", last_run, 8);
      chk("t1 busy_end", busy, 0);

      // Back-to-back 7E, FF
      base = q.size();
      load = 1'b1; data_in = 8'h7E; step();
      data_in = 8'hFF; step();
      load = 1'b0;
      wait_idle("t2");
      chk("t2 byte0", byte_at(base), 8'h7E);
      chk("t2 byte1", byte_at(base+8), 8'hFF);
      chk("t2 run", last_run, 16);

      // Full buffer: fourth word dropped
      base = q.size();
      load = 1'b1; data_in = 8'h01; step();
      data_in = 8'h02; step();
      chk("t3 ready_before_3rd", ready, 1);
      data_in = 8'h03; step();
      chk("t3 ready_before_4th", ready, 0);
      data_in = 8'h04; step();
      load = 1'b0;
      wait_idle("t3");
      chk("t3 bits", q.size() - base, 24);
      chk("t3 byte0", byte_at(base), 8'h01);
      chk("t3 byte1", byte_at(base+8), 8'h02);
      chk("t3 byte2", byte_at(base+16), 8'h03);
      chk("t3 run", last_run, 24);

      // Push and pop on the same last-bit edge keep count at one
      base = q.size();
      load = 1'b1; data_in = 8'h5A; step();
      data_in = 8'hC3; step();
      load = 1'b0;
      repeat (7) step();
      load = 1'b1; data_in = 8'h3C; step();
      load = 1'b0;
      chk("t4 ready_after_pushpop", ready, 1);
      chk("t4 busy_after_pushpop", busy, 1);
      wait_idle("t4");
      chk("t4 byte0", byte_at(base), 8'h5A);
      chk("t4 byte1", byte_at(base+8), 8'hC3);
      chk("t4 byte2", byte_at(base+16), 8'h3C);
      chk("t4 run", last_run, 24);

      // Reset after three bits of AA aborts immediately, nothing resumes
      base = q.size();
      load = 1'b1; data_in = 8'hAA; step();
      load = 1'b0;
      step(); step(); step();
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk("t5 serialout", serialout, 0);
      chk("t5 detect", detect, 0);
      chk("t5 ready", ready, 1);
      chk("t5 busy", busy, 0);
      step(); step();
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen += detect;
      end
      chk("t5 detect_after_release", seen, 0);
      chk("t5 partial_bits", q.size() - base, 3);
      chk("t5 partial_value", {q[base], q[base+1], q[base+2]}, 3'b101);

      // 7C stream as a detector would see it
      base = q.size();
      load = 1'b1; data_in = 8'h7C; step();
      load = 1'b0;
      wait_idle("t6");
      chk("t6 byte", byte_at(base), 8'h7C);
      chk("t6 run", last_run, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per parallel word.
REQ-002 Parameter DEPTH, default 2: words held in the input buffer, excluding the shift register.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port data_in, input, WIDTH: parallel word to send.
REQ-007 Port load, input, 1: data_in valid.
REQ-008 Port ready, output, 1: buffer can accept a word this cycle.
REQ-009 Port serialout, output, 1: serial bit stream, MSB first; feeds the detector's serialin.
REQ-010 Port detect, output, 1: serialout carries a valid bit this cycle; feeds the detector's detect.
REQ-011 Port busy, output, 1: shifting in progress or buffer non-empty.

Function
REQ-012 A word SHALL be accepted on a rising edge only when load=1 and ready=1; load while ready=0 is ignored and the word is dropped.
REQ-013 ready SHALL equal (buffer count < DEPTH), decoded combinationally from the registered count.
REQ-014 Buffer order SHALL be FIFO, with wrap-around of read and write pointers modulo DEPTH.
REQ-015 The FSM SHALL have two states, IDLE and SHIFT.
- IDLE -> SHIFT at an edge where the buffer is non-empty: pop the head word into the shift register and clear the bit counter.
REQ-016 In SHIFT, serialout SHALL be the shift-register MSB and detect=1.
- Each edge shifts left by one and increments the bit counter.
REQ-017 On the edge ending bit WIDTH-1, the FSM SHALL pop the next word and stay in SHIFT if the buffer is non-empty, with no gap cycle; otherwise it SHALL go to IDLE.
REQ-018 In IDLE, serialout=0 and detect=0.
REQ-019 Latency: for a word accepted at edge k into an empty, idle block, the first bit SHALL be visible after edge k+1.
- That word SHALL occupy exactly WIDTH consecutive detect=1 cycles.
REQ-020 A simultaneous push and pop in one edge SHALL leave the count unchanged and preserve order.
- When the buffer is full, the same-edge pop does not enable a push, because ready was 0 at the start of that cycle.
REQ-021 busy SHALL be 1 when the state is SHIFT or the count is non-zero, else 0.
REQ-022 serialout and detect SHALL be registered outputs with no combinational path from load or data_in.

Reset
REQ-023 While rst=0: state=IDLE, count=0, pointers=0, shift register=0, bit counter=0, serialout=0, detect=0, busy=0, ready=1.
REQ-024 Reset asserted mid-word SHALL abort immediately: the partial word and all buffered words are discarded.
- After release, no partial bits resume.
REQ-025 The first accepting edge SHALL be the first rising edge after rst goes high.

Structure
REQ-026 A shared package seq_pkg SHALL hold WIDTH_DEF=8, DEPTH_DEF=2 and the state enumeration (IDLE, SHIFT).
REQ-027 The buffer SHALL be a sub-module ser_fifo with ports clk, rst, push, pop, din, dout, count.
- The serializer SHALL instantiate it once; the FSM, shift register and bit counter live in serializer.

Verification
REQ-028 Single word: load 8'h7E for one cycle while idle -> serialout 0,1,1,1,1,1,1,0 over cycles 1..8 after acceptance, detect=1 for exactly those 8 cycles, then detect=0, busy=0.
REQ-029 Back-to-back: accept 8'h7E then 8'hFF on consecutive edges -> 16 contiguous detect=1 cycles; serialout 01111110 then 11111111; no gap cycle.
REQ-030 Full buffer: load 8'h01, 8'h02, 8'h03, 8'h04 on four consecutive edges -> ready=0 at the fourth edge, 8'h04 dropped, 24 contiguous detect cycles.
- Expected stream: 8'h01, 8'h02, 8'h03.
REQ-031 Reset mid-word: drive rst=0 after 3 bits of 8'hAA -> serialout=0, detect=0, ready=1 immediately.
- After release with no load, detect stays 0.
REQ-032 Simultaneous push/pop: buffer holding 1 word, load asserted on the last-bit edge -> count stays 1 and the words are sent in acceptance order.
REQ-033 End-to-end: drive the seq_detector from serialout/detect, send 8'h7C (01111100) -> detector output matches its expected response to the same bit stream applied directly.
